// File: rtl/neopixel_pkg.sv
// Shared constants and types for the NeoPixel strip controller.
package neopixel_pkg;

    localparam int NUM_PIXELS     = 5;
    localparam int NUM_COLORS     = 3;
    localparam int BITS_PER_PIXEL = 24;
    localparam int TOTAL_BITS     = NUM_PIXELS * BITS_PER_PIXEL;

    typedef enum logic [1:0] {
        GREEN = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2
    } color_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } neo_state_t;

endpackage

// File: rtl/neo_bit_timer.sv
// Times one WS2812 bit slot: high for T1H or T0H cycles, then low until TBIT.
// The counter runs while start is held and self-clears at the end of each slot.
module neo_bit_timer #(
    parameter int T0H  = 18,
    parameter int T1H  = 35,
    parameter int TBIT = 63
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic bit_done,
    output logic data
);

    localparam int CW = $clog2(TBIT);
    localparam logic [CW-1:0] T0H_C  = CW'(T0H);
    localparam logic [CW-1:0] T1H_C  = CW'(T1H);
    localparam logic [CW-1:0] LAST_C = CW'(TBIT - 1);

    logic [CW-1:0] cyc_ctr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_ctr <= '0;
        end else if (!start || cyc_ctr == LAST_C) begin
            cyc_ctr <= '0;
        end else begin
            cyc_ctr <= cyc_ctr + 1'b1;
        end
    end

    assign bit_done = start && (cyc_ctr == LAST_C);
    assign data     = start && (cyc_ctr < (bit_val ? T1H_C : T0H_C));

endmodule

// File: rtl/neopixel_controller.sv
// Stores 5 pixels of G/R/B levels and serializes them onto a WS2812 data line.
// Optional brightness cap on writes: define NEO_BRIGHTNESS_LIMIT_EN.
module neopixel_controller
    import neopixel_pkg::*;
#(
    parameter int         T0H       = 18,
    parameter int         T1H       = 35,
    parameter int         TBIT      = 63,
    parameter int         TRESET    = 2500,
    parameter logic [7:0] MAX_LEVEL = 8'h20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_color,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       send_it,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       begin_send,
    output logic       done_send,
    output logic       done_wait,
    output logic       neo_data
);

    localparam int WW = $clog2(TRESET);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TRESET - 1);
    localparam logic [6:0]    BIT_LAST  = 7'(TOTAL_BITS - 1);

    if (TBIT <= T1H || MAX_LEVEL == 8'h00) begin : g_bad_params
        $error("neopixel_controller: TBIT must exceed T1H and MAX_LEVEL must be nonzero");
    end

    neo_state_t    state, state_next;
    logic [7:0]    levels [NUM_PIXELS][NUM_COLORS];
    logic [6:0]    bit_ctr;
    logic [WW-1:0] wait_ctr;
    logic          idle_q;
    logic          sending, bit_done, cur_bit, tx_data, write_ok;
    logic [2:0]    pix_sel;
    logic [4:0]    bit_in_pix;
    color_t        col_sel;

    function automatic logic [7:0] store_level(input logic [7:0] lvl);
`ifdef NEO_BRIGHTNESS_LIMIT_EN
        return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
`else
        return lvl;
`endif
    endfunction

    assign sending  = (state == SEND);
    assign write_ok = (state == IDLE) && load_color &&
                      (pixel_index < 3'(NUM_PIXELS)) && (color_index < 2'(NUM_COLORS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                for (int c = 0; c < NUM_COLORS; c++) begin
                    levels[p][c] <= '0;
                end
            end
        end else if (write_ok) begin
            levels[pixel_index][color_index] <= store_level(color_level);
        end
    end

    // Stream order: pixel 0..4, G/R/B within a pixel, MSB first within a color.
    always_comb begin
        pix_sel    = 3'(bit_ctr / 7'(BITS_PER_PIXEL));
        bit_in_pix = 5'(bit_ctr % 7'(BITS_PER_PIXEL));
        col_sel    = color_t'(bit_in_pix[4:3]);
        cur_bit    = levels[pix_sel][col_sel][3'd7 - bit_in_pix[2:0]];
    end

    neo_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_timer (
        .clock    (clock),
        .reset    (reset),
        .start    (sending),
        .bit_val  (cur_bit),
        .bit_done (bit_done),
        .data     (tx_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idle_q   <= 1'b1;
            bit_ctr  <= '0;
            wait_ctr <= '0;
        end else begin
            state  <= state_next;
            idle_q <= (state == IDLE);
            if (sending && bit_done) begin
                bit_ctr <= (bit_ctr == BIT_LAST) ? '0 : bit_ctr + 1'b1;
            end
            if (state == WAIT) begin
                wait_ctr <= (wait_ctr == WAIT_LAST) ? '0 : wait_ctr + 1'b1;
            end else begin
                wait_ctr <= '0;
            end
        end
    end

    always_comb begin
        state_next    = state;
        ready_to_load = 1'b0;
        ready_to_send = 1'b0;
        begin_send    = 1'b0;
        done_send     = 1'b0;
        done_wait     = 1'b0;
        neo_data      = 1'b0;
        unique case (state)
            IDLE: begin
                ready_to_load = 1'b1;
                ready_to_send = 1'b1;
                if (send_it) state_next = SEND;
            end
            SEND: begin
                neo_data   = tx_data;
                begin_send = idle_q;
                if (bit_done && bit_ctr == BIT_LAST) state_next = WAIT;
            end
            WAIT: begin
                done_send = (wait_ctr == '0);
                done_wait = (wait_ctr == WAIT_LAST);
                if (done_wait) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_neopixel_controller.sv
// Self-checking bench for neopixel_controller using a bit-stream reference model.
module tb_neopixel_controller;

    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRESET = 10;
    localparam int NBITS  = 120;

    logic       clock = 1'b0;
    logic       reset, load_color, send_it;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       ready_to_load, ready_to_send, begin_send, done_send, done_wait, neo_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [5][3];

    typedef struct {
        logic [2:0] pix;
        logic [1:0] col;
        logic [7:0] lvl;
        int         first_bit;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[7];

    always #5 clock = ~clock;

    neopixel_controller #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TRESET (TRESET)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .load_color    (load_color),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .send_it       (send_it),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .begin_send    (begin_send),
        .done_send     (done_send),
        .done_wait     (done_wait),
        .neo_data      (neo_data)
    );

    function automatic logic [7:0] cap(input logic [7:0] v);
`ifdef NEO_BRIGHTNESS_LIMIT_EN
        return (v > 8'h20) ? 8'h20 : v;
`else
        return v;
`endif
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [119:0] act, input logic [119:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 3; c++)
                mem[p][c] = 8'h00;
    endfunction

    function automatic void model_write(input logic [2:0] p, input logic [1:0] c, input logic [7:0] v);
        if (p < 3'd5 && c < 2'd3) mem[p][c] = cap(v);
    endfunction

    // Bit b of the transmission lands at position 119-b.
    function automatic logic [119:0] model_stream();
        logic [119:0] s = '0;
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 3; c++)
                for (int i = 7; i >= 0; i--)
                    s = {s[118:0], mem[p][c][i]};
        return s;
    endfunction

    task automatic load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] v);
        load_color  = 1'b1;
        pixel_index = p;
        color_index = c;
        color_level = v;
        model_write(p, c, v);
        @(negedge clock);
        load_color = 1'b0;
    endtask

    task automatic do_send(input string tag, input bit with_load, input logic [2:0] lp,
                           input logic [1:0] lc, input logic [7:0] lv, input bit noise,
                           output logic [119:0] got);
        logic [119:0] exp_s;
        int           hi[NBITS];
        int           werr = 0;
        int           bs_cnt = 0;
        logic         bs_first;
        logic         exp_hi;
        send_it = 1'b1;
        if (with_load) begin
            load_color  = 1'b1;
            pixel_index = lp;
            color_index = lc;
            color_level = lv;
            model_write(lp, lc, lv);
        end
        exp_s = model_stream();
        for (int b = 0; b < NBITS; b++) hi[b] = 0;
        bs_first = 1'b0;
        for (int k = 0; k < NBITS * TBIT; k++) begin
            @(negedge clock);
            if (k == 0) begin
                send_it    = 1'b0;
                load_color = 1'b0;
                bs_first   = begin_send;
            end
            if (begin_send) bs_cnt++;
            if (ready_to_load || ready_to_send || done_send || done_wait) werr++;
            exp_hi = ((k % TBIT) < (exp_s[119 - k / TBIT] ? T1H : T0H));
            if (neo_data !== exp_hi) werr++;
            if (neo_data) hi[k / TBIT]++;
            if (noise) begin
                load_color  = 1'($urandom);
                send_it     = 1'($urandom);
                pixel_index = 3'($urandom);
                color_index = 2'($urandom);
                color_level = 8'($urandom);
            end
        end
        for (int w = 0; w < TRESET; w++) begin
            @(negedge clock);
            if (done_send !== (w == 0)) werr++;
            if (done_wait !== (w == TRESET - 1)) werr++;
            if (neo_data || ready_to_load || ready_to_send || begin_send) werr++;
            if (noise && w < TRESET - 1) begin
                load_color = 1'($urandom);
                send_it    = 1'($urandom);
            end else begin
                load_color = 1'b0;
                send_it    = 1'b0;
            end
        end
        @(negedge clock);
        check_bit({tag, "_idle_return"}, ready_to_load && ready_to_send, 1'b1);
        check_bit({tag, "_begin_first"}, bs_first, 1'b1);
        check_int({tag, "_begin_count"}, bs_cnt, 1);
        check_int({tag, "_waveform_errs"}, werr, 0);
        got = '0;
        for (int b = 0; b < NBITS; b++) got[119 - b] = (hi[b] == T1H);
    endtask

    initial begin
        logic [119:0] got;
        logic [7:0]   cv;
        reset       = 1'b1;
        load_color  = 1'b0;
        send_it     = 1'b0;
        pixel_index = '0;
        color_index = '0;
        color_level = '0;
        model_clear();
        @(negedge clock);
        check_bit("rst_ready_to_load", ready_to_load, 1'b1);
        check_bit("rst_ready_to_send", ready_to_send, 1'b1);
        check_bit("rst_neo_data", neo_data, 1'b0);
        check_bit("rst_pulses", begin_send | done_send | done_wait, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check_bit("idle_ready", ready_to_load && ready_to_send, 1'b1);
        check_bit("idle_neo_data", neo_data, 1'b0);

        do_send("zeros", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, got);
        check_vec("zeros_bits", got, '0);

        vecs[0] = '{3'd0, 2'd0, 8'hA5, 0,   cap(8'hA5)};
        vecs[1] = '{3'd4, 2'd2, 8'h01, 112, cap(8'h01)};
        vecs[2] = '{3'd7, 2'd1, 8'hFF, 8,   8'h00};
        vecs[3] = '{3'd1, 2'd3, 8'hFF, 32,  8'h00};
        vecs[4] = '{3'd2, 2'd1, 8'h3C, 56,  cap(8'h3C)};
        vecs[5] = '{3'd3, 2'd0, 8'hC3, 72,  cap(8'hC3)};
        vecs[6] = '{3'd2, 2'd0, 8'hFF, 48,  cap(8'hFF)};
        foreach (vecs[i]) load(vecs[i].pix, vecs[i].col, vecs[i].lvl);
        do_send("table", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, got);
        foreach (vecs[i]) begin
            check_vec($sformatf("table_byte_%0d", i), 120'(got[119 - vecs[i].first_bit -: 8]),
                      120'(vecs[i].exp_byte));
        end

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        load(3'd4, 2'd2, 8'h01);
        load(3'd7, 2'd1, 8'hFF);
        do_send("last_bit", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, got);
        check_vec("only_bit119", got, 120'h1);

        cv = cap(8'h80);
        do_send("same_cycle", 1'b1, 3'd1, 2'd1, 8'h80, 1'b0, got);
        check_bit("same_cycle_bit32", got[119 - 32], cv[7]);

        do_send("noisy", 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, got);
        do_send("after_noise", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, got);
        check_vec("after_noise_bits", got, model_stream());

        load(3'd0, 2'd1, 8'h5A);
        send_it = 1'b1;
        @(negedge clock);
        send_it = 1'b0;
        repeat (50 * TBIT + 2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_bit("midreset_neo_data", neo_data, 1'b0);
        check_bit("midreset_idle", ready_to_load && ready_to_send, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        do_send("after_reset", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, got);
        check_vec("after_reset_bits", got, '0);

        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(3, 8))
                load(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom));
            do_send($sformatf("rand%0d", it), 1'($urandom), 3'($urandom), 2'($urandom),
                    8'($urandom), 1'($urandom), got);
            check_vec($sformatf("rand%0d_bits", it), got, model_stream());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neopixel_controller.md
# neopixel_controller

- Consumer end of the NeoPixel load/send handshake: accepts per-color levels for a 5-pixel strip from a producer FSM.
- On request, serializes all 120 bits onto the one-wire `neo_data` line using WS2812 pulse-width encoding, then holds the latch/reset gap.
- Sits between the pattern-producer FSM and the strip's data pin; drives every handshake input that the producer samples.

## Interface

Parameters:
- `T0H`, default 18: high cycles for a 0 bit (0.35 µs at 50 MHz).
- `T1H`, default 35: high cycles for a 1 bit.
- `TBIT`, default 63: total cycles per bit; must be greater than `T1H`.
- `TRESET`, default 2500: low cycles of the latch gap (50 µs).
- `MAX_LEVEL`, default 8'h20: brightness cap (only used when the feature is compiled in).

Ports:
- `clock`, input, 1: single clock domain.
- `reset`, input, 1: asynchronous, active-high reset.
- `load_color`, input, 1: write strobe, one write per asserted cycle.
- `pixel_index`, input, 3: pixel 0–4; values 5–7 are ignored.
- `color_index`, input, 2: 0 = green, 1 = red, 2 = blue; 3 is ignored.
- `color_level`, input, 8: level to store.
- `send_it`, input, 1: start transmission.
- `ready_to_load`, output, 1: writes accepted this cycle.
- `ready_to_send`, output, 1: `send_it` accepted this cycle.
- `begin_send`, output, 1: one-cycle pulse on the first SEND cycle.
- `done_send`, output, 1: one-cycle pulse on the first WAIT cycle.
- `done_wait`, output, 1: one-cycle pulse on the last WAIT cycle.
- `neo_data`, output, 1: strip data line.

## Operation

- Storage: 15 × 8-bit registers, indexed [pixel][color].
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - `ready_to_load` = `ready_to_send` = 1; `neo_data` = 0.
  - `load_color` with valid indices writes `color_level` at the clock edge. Invalid indices produce no write and no error.
  - `send_it` moves to SEND.
- SEND:
  - Bit order: pixel 0 → 4; within each pixel G, R, B; MSB first within each color.
  - `bit_ctr` counts 0..119; `cyc_ctr` counts 0..TBIT−1.
  - `neo_data` = (`cyc_ctr` < (bit ? T1H : T0H)).
  - After the last cycle of bit 119, move to WAIT.
- WAIT:
  - `neo_data` = 0 for TRESET cycles, then return to IDLE.
- Outside IDLE: `load_color` and `send_it` are ignored, and both ready outputs are 0.
- `load_color` and `send_it` in the same IDLE cycle: the write commits and transmission starts next cycle, so the new value is transmitted.
- Registers are only ever written by `load_color`; a completed send does not clear them.

## Timing

- Reset values:
  - State IDLE; all storage 0; counters 0.
  - `neo_data` = 0; `begin_send` = `done_send` = `done_wait` = 0.
  - `ready_to_load` = `ready_to_send` = 1.
- Ready outputs decode from the state register only; there is no combinational path from the inputs.
- Send latency:
  - `send_it` sampled at edge N → SEND from cycle N+1.
  - `begin_send` = 1 and `neo_data` = 1 in cycle N+1.
- SEND lasts exactly 120·TBIT cycles.
- `done_send` pulses in WAIT cycle 0; `done_wait` pulses in WAIT cycle TRESET−1.
- IDLE resumes on the following cycle. Full turnaround is 120·TBIT + TRESET cycles.
- Asserting `reset` mid-SEND or mid-WAIT aborts immediately: `neo_data` = 0, IDLE, storage cleared.
- Counter widths:
  - `cyc_ctr`: $clog2(TBIT).
  - `bit_ctr`: 7 bits.
  - Wait counter: $clog2(TRESET).
  - No counter wraps except by explicit clear at its terminal value.

## Configuration

- Macro: `NEO_BRIGHTNESS_LIMIT_EN`.
- When defined, every write stores min(`color_level`, MAX_LEVEL). A write of 8'hFF with the default cap stores 8'h20.
- When undefined, `color_level` is stored unmodified and `MAX_LEVEL` is unused.

## Structure

- Package `neopixel_pkg` holds:
  - `NUM_PIXELS` = 5, `NUM_COLORS` = 3, `BITS_PER_PIXEL` = 24.
  - `color_t` enum: GREEN = 0, RED = 1, BLUE = 2.
  - `neo_state_t` enum: IDLE, SEND, WAIT.
- One sub-module, `neo_bit_timer`:
  - Owns `cyc_ctr`.
  - Inputs: `start`, `bit_val`. Outputs: `bit_done` pulse, pulse-width-encoded `data` level.
- Top level holds the FSM, storage, `bit_ctr`, bit-select mux and wait counter.

## Test plan

All scenarios use T0H=2, T1H=4, TBIT=6, TRESET=10.

- Reset then idle: `ready_to_load` = `ready_to_send` = 1 and `neo_data` = 0; `send_it` gives 120 bits each high 2/low 4 cycles, and the total SEND length is 720 cycles.
- Load pixel 0 G = 8'hA5, then send: the first 8 bits show high widths 4,2,4,2,2,4,2,4; `begin_send` pulses once on the first SEND cycle.
- Load pixel 4 B = 8'h01 and pixel 7 R = 8'hFF, then send: bit 119 is 1; no other bit is 1.
- Same-cycle `load_color` (pixel 1 R = 8'h80) and `send_it`: bit 32 is transmitted as 1.
- `load_color` and `send_it` during SEND and WAIT: storage unchanged and no restart; `done_send` comes at SEND+720 cycles, `done_wait` 9 cycles later, IDLE 1 cycle after that.
- Reset asserted at bit 50: `neo_data` drops to 0 immediately, state is IDLE, and a readback send transmits all zeros.
- With `NEO_BRIGHTNESS_LIMIT_EN`, load 8'hFF → transmitted as 8'h20.
